bus_source_encoder: RTL and testbench

Registered encoder that converts the control unit's one-hot bus-source requests (R0out…Cout) into the 5-bit bus multiplexer select code. It sits between the control unit and the 32:1 bus multiplexer, and is the encode side of that select interface. It also detects multi-driver contention and keeps contention statistics for debug.

---
 rtl/bus_source_encoder_if.sv | 27 ++
 rtl/bus_source_encoder.sv | 102 ++++++++++
 tb/tb_bus_source_encoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bus_source_encoder_if.sv
// Select interface between the control unit (master) and the bus source encoder (slave).
interface bus_source_encoder_if #(
  parameter int unsigned NUM_SRC = 25,
  parameter int unsigned CNT_W   = 8
);
  logic [NUM_SRC-1:0] req;
  logic               hold;
  logic               clr_err;
  logic [4:0]         sel;
  logic               sel_valid;
  logic               multi_err;
  logic               err_sticky;
  logic [NUM_SRC-1:0] err_snap;
  logic [CNT_W-1:0]   err_cnt;

  // Control-unit side: drives requests, observes select and debug state.
  modport master (
    output req, hold, clr_err,
    input  sel, sel_valid, multi_err, err_sticky, err_snap, err_cnt
  );

  // Encoder side.
  modport slave (
    input  req, hold, clr_err,
    output sel, sel_valid, multi_err, err_sticky, err_snap, err_cnt
  );
endinterface

// File: rtl/bus_source_encoder.sv
// Registered one-hot to 5-bit bus-mux select encoder with contention detection and statistics.
module bus_source_encoder #(
  parameter int unsigned NUM_SRC = 25,
  parameter int unsigned CNT_W   = 8
) (
  input logic                 clock,
  input logic                 clear,
  bus_source_encoder_if.slave bus
);

  localparam logic [4:0]       SelNone = 5'b11111;
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StIdle, StDrive, StContend} state_e;

  state_e             state_q, state_d;
  logic [4:0]         sel_q, sel_d;
  logic               multi_err_q, multi_err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [NUM_SRC-1:0] err_snap_q, err_snap_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [4:0]         sel_enc;
  logic               any_req;
  logic               multi_req;
  logic               contend;
  logic [CNT_W-1:0]   cnt_base;

  // Lowest set index wins; scanning high-to-low leaves the lowest one last.
  always_comb begin
    sel_enc = SelNone;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.req[i]) sel_enc = 5'(i);
    end
  end

  // Request classification; x & (x-1) is nonzero iff two or more bits are set.
  always_comb begin
    any_req   = |bus.req;
    multi_req = |(bus.req & (bus.req - NUM_SRC'(1)));
    contend   = multi_req && !bus.hold;
  end

  // Next-state FSM and select/pulse outputs; hold freezes everything except the pulse.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    multi_err_d = 1'b0;
    if (!bus.hold) begin
      sel_d       = sel_enc;
      multi_err_d = multi_req;
      if (multi_req)    state_d = StContend;
      else if (any_req) state_d = StDrive;
      else              state_d = StIdle;
    end
  end

  // Debug statistics; clr_err clears first, then a same-cycle contention is recorded afresh.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_snap_d   = err_snap_q;
    cnt_base     = err_cnt_q;
    if (bus.clr_err) begin
      err_sticky_d = 1'b0;
      err_snap_d   = '0;
      cnt_base     = '0;
    end
    err_cnt_d = cnt_base;
    if (contend) begin
      if (!err_sticky_d) err_snap_d = bus.req;
      err_sticky_d = 1'b1;
      if (cnt_base != CntMax) err_cnt_d = cnt_base + CNT_W'(1);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= StIdle;
      sel_q        <= SelNone;
      multi_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_snap_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      multi_err_q  <= multi_err_d;
      err_sticky_q <= err_sticky_d;
      err_snap_q   <= err_snap_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_valid  = (state_q != StIdle);
  assign bus.multi_err  = multi_err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_snap   = err_snap_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bus_source_encoder.sv
// Directed self-checking bench for bus_source_encoder.
module tb_bus_source_encoder;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  bus_source_encoder_if #(.NUM_SRC(25), .CNT_W(8)) bus ();

  bus_source_encoder #(.NUM_SRC(25), .CNT_W(8)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset overrides hold and a full request vector.
    bus.req     = 25'h1FFFFFF;
    bus.hold    = 1'b1;
    bus.clr_err = 1'b0;
    clear       = 1'b0;
    step();
    check("rst_sel", 32'(bus.sel), 32'h1F);
    check("rst_valid", 32'(bus.sel_valid), 32'h0);
    check("rst_merr", 32'(bus.multi_err), 32'h0);
    check("rst_sticky", 32'(bus.err_sticky), 32'h0);
    check("rst_snap", 32'(bus.err_snap), 32'h0);
    check("rst_cnt", 32'(bus.err_cnt), 32'h0);
    clear    = 1'b1;
    bus.hold = 1'b0;
    bus.req  = '0;
    step();
    check("idle_sel", 32'(bus.sel), 32'h1F);

    // Walk a single source through every position.
    for (int i = 0; i < 25; i++) begin
      bus.req = 25'(1) << i;
      step();
      check($sformatf("walk_sel_%0d", i), 32'(bus.sel), 32'(i));
      check($sformatf("walk_valid_%0d", i), 32'(bus.sel_valid), 32'h1);
      check($sformatf("walk_merr_%0d", i), 32'(bus.multi_err), 32'h0);
    end
    bus.req = '0;
    step();
    check("none_sel", 32'(bus.sel), 32'h1F);
    check("none_valid", 32'(bus.sel_valid), 32'h0);

    // First contention: PCout and R3out.
    bus.req = 25'h100008;
    step();
    check("c1_sel", 32'(bus.sel), 32'h3);
    check("c1_merr", 32'(bus.multi_err), 32'h1);
    check("c1_sticky", 32'(bus.err_sticky), 32'h1);
    check("c1_snap", 32'(bus.err_snap), 32'h100008);
    check("c1_cnt", 32'(bus.err_cnt), 32'h1);
    bus.req = 25'h000060;
    step();
    check("c2_sel", 32'(bus.sel), 32'h5);
    check("c2_snap", 32'(bus.err_snap), 32'h100008);
    check("c2_cnt", 32'(bus.err_cnt), 32'h2);
    bus.req = 25'h000010;
    step();
    check("c3_merr", 32'(bus.multi_err), 32'h0);
    check("c3_sticky", 32'(bus.err_sticky), 32'h1);
    check("c3_cnt", 32'(bus.err_cnt), 32'h2);

    // Saturation over 300 contention cycles.
    bus.req = 25'h000003;
    for (int i = 0; i < 300; i++) begin
      step();
      check($sformatf("sat_merr_%0d", i), 32'(bus.multi_err), 32'h1);
    end
    check("sat_cnt", 32'(bus.err_cnt), 32'd255);
    step();
    check("sat_cnt_stay", 32'(bus.err_cnt), 32'd255);
    check("sat_sticky", 32'(bus.err_sticky), 32'h1);

    // Clear statistics.
    bus.req     = '0;
    bus.clr_err = 1'b1;
    step();
    check("clr_cnt", 32'(bus.err_cnt), 32'h0);
    check("clr_sticky", 32'(bus.err_sticky), 32'h0);
    check("clr_snap", 32'(bus.err_snap), 32'h0);
    bus.clr_err = 1'b0;

    // Hold freezes MDRout selection and masks contention.
    bus.req = 25'(1) << 21;
    step();
    check("h_pre_sel", 32'(bus.sel), 32'd21);
    bus.hold = 1'b1;
    bus.req  = 25'h000003;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("h_sel_%0d", i), 32'(bus.sel), 32'd21);
      check($sformatf("h_merr_%0d", i), 32'(bus.multi_err), 32'h0);
      check($sformatf("h_cnt_%0d", i), 32'(bus.err_cnt), 32'h0);
      check($sformatf("h_valid_%0d", i), 32'(bus.sel_valid), 32'h1);
    end
    bus.hold = 1'b0;
    step();
    check("h_rel_sel", 32'(bus.sel), 32'h0);
    check("h_rel_merr", 32'(bus.multi_err), 32'h1);
    check("h_rel_cnt", 32'(bus.err_cnt), 32'h1);
    check("h_rel_snap", 32'(bus.err_snap), 32'h3);

    // Build count to 5, then clr_err with simultaneous contention.
    for (int i = 0; i < 4; i++) step();
    check("pre_cnt5", 32'(bus.err_cnt), 32'h5);
    bus.req     = 25'h000006;
    bus.clr_err = 1'b1;
    step();
    check("cc_cnt", 32'(bus.err_cnt), 32'h1);
    check("cc_snap", 32'(bus.err_snap), 32'h6);
    check("cc_sticky", 32'(bus.err_sticky), 32'h1);
    check("cc_sel", 32'(bus.sel), 32'h1);

    // clr_err acts under hold while contention is ignored.
    bus.hold = 1'b1;
    step();
    check("ch_cnt", 32'(bus.err_cnt), 32'h0);
    check("ch_sticky", 32'(bus.err_sticky), 32'h0);
    check("ch_merr", 32'(bus.multi_err), 32'h0);
    bus.hold    = 1'b0;
    bus.clr_err = 1'b0;

    // Reset mid-burst discards everything.
    bus.req = 25'h000300;
    step();
    check("burst_cnt", 32'(bus.err_cnt), 32'h1);
    clear = 1'b0;
    step();
    check("mrst_sel", 32'(bus.sel), 32'h1F);
    check("mrst_valid", 32'(bus.sel_valid), 32'h0);
    check("mrst_merr", 32'(bus.multi_err), 32'h0);
    check("mrst_sticky", 32'(bus.err_sticky), 32'h0);
    check("mrst_snap", 32'(bus.err_snap), 32'h0);
    check("mrst_cnt", 32'(bus.err_cnt), 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
